// File: rtl/fetch_prefetch.sv
// fetch_prefetch: runs ahead of the core, reading 32-bit big-endian words over
// Wishbone into a halfword FIFO, and presents 16/32/48-bit instructions from
// the FIFO head to decode.
//
// Decode handshake: an instruction transfers on any cycle where o_valid and
// i_ready are both high. o_valid never depends on i_ready, and the head stays
// stable while o_valid && !i_ready, except that i_flush discards it.
module fetch_prefetch #(
    parameter int unsigned DEPTH_HW = 8,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        i_clk,
    input  logic        i_reset,
    output logic [31:0] o_wb_addr,
    output logic        o_wb_cyc,
    output logic        o_wb_stb,
    output logic [3:0]  o_wb_sel,
    output logic        o_wb_we,
    output logic [31:0] o_wb_dat,
    input  logic [31:0] i_wb_dat,
    input  logic        i_wb_ack,
    input  logic        i_wb_err,
    input  logic        i_flush,
    input  logic [31:0] i_flush_pc,
    output logic [47:0] o_instruction,
    output logic [31:0] o_pc,
    output logic [1:0]  o_len,
    output logic        o_valid,
    input  logic        i_ready,
    output logic        o_error,
    output logic [31:0] o_error_addr
);
    localparam int unsigned AW = $clog2(DEPTH_HW);
    localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH_HW);

    // IDLE waits for FIFO room, BUS holds one read cycle, HALT parks after a bus error.
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_BUS = 2'd1, S_HALT = 2'd2} state_t;

    state_t        state_q, state_d;
    logic [31:0]   f_pc_q, f_pc_d;
    logic [31:0]   pc_q, pc_d;
    logic          err_q, err_d;
    logic [31:0]   err_addr_q, err_addr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr;
    logic [AW:0]   cnt_q, cnt_d, free, push_n, pop_n;
    logic [15:0]   fifo_q [DEPTH_HW];
    logic [15:0]   hw0, hw1, hw2;
    logic [1:0]    len;
    logic          room, bus_ack, bus_err, accept, valid;
    logic          unused_fpc_bit0;

    assign unused_fpc_bit0 = f_pc_q[0];

    // Head of FIFO, plus the two halfwords that may complete a long instruction.
    assign hw0 = fifo_q[rd_ptr_q];
    assign hw1 = fifo_q[rd_ptr_q + AW'(1)];
    assign hw2 = fifo_q[rd_ptr_q + AW'(2)];

    // Instruction length in halfwords from the head amode field.
    always_comb begin
        len = 2'd1;
        casez (hw0[2:0])
            3'b000:  len = 2'd1;
            3'b001:  len = 2'd2;
            3'b01?:  len = 2'd3;
            default: len = 2'd1;
        endcase
    end

    assign valid         = cnt_q >= {{(AW - 1){1'b0}}, len};
    assign accept        = valid && i_ready;
    assign o_valid       = valid;
    assign o_len         = len;
    assign o_pc          = pc_q;
    assign o_instruction = {hw0, (len != 2'd1) ? hw1 : 16'h0000, (len == 2'd3) ? hw2 : 16'h0000};
    assign o_error       = err_q;
    assign o_error_addr  = err_addr_q;

    assign o_wb_cyc  = (state_q == S_BUS);
    assign o_wb_stb  = (state_q == S_BUS);
    assign o_wb_addr = {f_pc_q[31:2], 2'b00};
    assign o_wb_sel  = (state_q != S_BUS) ? 4'b0000 : (f_pc_q[1] ? 4'b0011 : 4'b1111);
    assign o_wb_we   = 1'b0;
    assign o_wb_dat  = 32'h0000_0000;

    // A word fetch needs two free slots; a fetch landing mid-word needs one.
    assign free    = DEPTH_C - cnt_q;
    assign room    = f_pc_q[1] ? (free >= (AW + 1)'(1)) : (free >= (AW + 1)'(2));
    assign bus_err = (state_q == S_BUS) && i_wb_err;
    assign bus_ack = (state_q == S_BUS) && i_wb_ack && !i_wb_err;
    assign push_n  = (bus_ack && !i_flush) ? (f_pc_q[1] ? (AW + 1)'(1) : (AW + 1)'(2)) : '0;
    assign pop_n   = accept ? {{(AW - 1){1'b0}}, len} : '0;
    assign wr_ptr  = rd_ptr_q + cnt_q[AW-1:0];

    // Next state: flush overrides bus responses and decode acceptance.
    always_comb begin
        state_d    = state_q;
        f_pc_d     = f_pc_q;
        pc_d       = pc_q;
        err_d      = err_q;
        err_addr_d = err_addr_q;
        rd_ptr_d   = rd_ptr_q;
        cnt_d      = cnt_q;
        if (i_flush) begin
            state_d  = S_IDLE;
            f_pc_d   = i_flush_pc & ~32'h1;
            pc_d     = i_flush_pc & ~32'h1;
            err_d    = 1'b0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            case (state_q)
                S_IDLE: if (room) state_d = S_BUS;
                S_BUS: begin
                    if (bus_err) begin
                        err_d      = 1'b1;
                        err_addr_d = {f_pc_q[31:2], 2'b00};
                        state_d    = S_HALT;
                    end else if (bus_ack) begin
                        f_pc_d  = {f_pc_q[31:2] + 30'd1, 2'b00};
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_HALT;
            endcase
            if (accept) begin
                rd_ptr_d = rd_ptr_q + AW'(len);
                pc_d     = pc_q + {29'd0, len, 1'b0};
            end
            cnt_d = cnt_q + push_n - pop_n;
        end
    end

    // Control registers with asynchronous reset.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q    <= S_IDLE;
            f_pc_q     <= RESET_PC & ~32'h1;
            pc_q       <= RESET_PC & ~32'h1;
            err_q      <= 1'b0;
            err_addr_q <= 32'h0000_0000;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            f_pc_q     <= f_pc_d;
            pc_q       <= pc_d;
            err_q      <= err_d;
            err_addr_q <= err_addr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
        end
    end

    // Halfword storage; only slots below cnt_q are ever read as valid, so no reset.
    always_ff @(posedge i_clk) begin
        if (push_n != '0) begin
            if (f_pc_q[1]) begin
                fifo_q[wr_ptr] <= i_wb_dat[15:0];
            end else begin
                fifo_q[wr_ptr]          <= i_wb_dat[31:16];
                fifo_q[wr_ptr + AW'(1)] <= i_wb_dat[15:0];
            end
        end
    end
endmodule

// File: tb/tb_fetch_prefetch.sv
// tb_fetch_prefetch: drives fetch_prefetch with a Wishbone memory responder and
// a random decode consumer; expectations come from an instruction-stream model
// that walks memory by address.
module tb_fetch_prefetch;
    localparam int DEPTH = 8;
    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        i_clk, i_reset;
    logic [31:0] o_wb_addr, o_wb_dat, i_wb_dat, i_flush_pc, o_pc, o_error_addr;
    logic        o_wb_cyc, o_wb_stb, o_wb_we, i_wb_ack, i_wb_err, i_flush;
    logic [3:0]  o_wb_sel;
    logic [47:0] o_instruction;
    logic [1:0]  o_len;
    logic        o_valid, i_ready, o_error;

    fetch_prefetch #(.DEPTH_HW(DEPTH), .RESET_PC(RST_PC)) dut (
        .i_clk(i_clk), .i_reset(i_reset),
        .o_wb_addr(o_wb_addr), .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb),
        .o_wb_sel(o_wb_sel), .o_wb_we(o_wb_we), .o_wb_dat(o_wb_dat),
        .i_wb_dat(i_wb_dat), .i_wb_ack(i_wb_ack), .i_wb_err(i_wb_err),
        .i_flush(i_flush), .i_flush_pc(i_flush_pc),
        .o_instruction(o_instruction), .o_pc(o_pc), .o_len(o_len),
        .o_valid(o_valid), .i_ready(i_ready),
        .o_error(o_error), .o_error_addr(o_error_addr)
    );

    // Clock.
    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    int total = 0;
    int bad   = 0;

    logic [31:0] mem [256];
    logic [81:0] exp_q [$];          // {instruction, pc, len} for directed checks
    logic [31:0] pc_exp, fetch_pc, err_addr_exp;
    logic        err_exp;
    int          ready_pct, min_wait, max_wait, wait_left, ack_cnt, delivered;
    logic        req_active, err_en, flush_req, armed, hit;
    logic [31:0] err_addr_trig, flush_pc_v, arm_pc;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] hw_at(input logic [31:0] a);
        logic [31:0] w;
        w = mem[a[9:2]];
        return a[1] ? w[15:0] : w[31:16];
    endfunction

    function automatic logic [1:0] len_of(input logic [15:0] h);
        if (h[2]) return 2'd1;
        else if (h[1]) return 2'd3;
        else if (h[0]) return 2'd2;
        return 2'd1;
    endfunction

    function automatic logic [47:0] instr_at(input logic [31:0] pc, input logic [1:0] n);
        logic [47:0] r;
        r = {hw_at(pc), 32'h0};
        if (n >= 2'd2) r[31:16] = hw_at(pc + 32'd2);
        if (n == 2'd3) r[15:0] = hw_at(pc + 32'd4);
        return r;
    endfunction

    task automatic model_reset();
        pc_exp       = RST_PC & ~32'h1;
        fetch_pc     = RST_PC & ~32'h1;
        err_exp      = 1'b0;
        err_addr_exp = 32'h0;
        req_active   = 1'b0;
        exp_q.delete();
    endtask

    // One clock: check DUT against the model, drive inputs for the next edge,
    // then advance the model by what that edge will do.
    task automatic step_cycle();
        logic [1:0]  el;
        logic        ev;
        logic [47:0] ei;
        logic [31:0] nbuf;
        logic [81:0] e;
        @(negedge i_clk);
        el   = len_of(hw_at(pc_exp));
        ei   = instr_at(pc_exp, el);
        nbuf = (fetch_pc - pc_exp) >> 1;
        ev   = (nbuf >= 32'(el));
        check("valid", o_valid, ev);
        if (ev) begin
            check("pc", o_pc, pc_exp);
            check("len", o_len, el);
            check("instr", o_instruction, ei);
        end
        check("error", o_error, err_exp);
        if (err_exp) begin
            check("err_addr", o_error_addr, err_addr_exp);
            check("halt_no_req", o_wb_cyc, 1'b0);
        end
        if (o_wb_cyc && !req_active) begin
            check("stb", o_wb_stb, 1'b1);
            check("addr", o_wb_addr, {fetch_pc[31:2], 2'b00});
            check("sel", o_wb_sel, fetch_pc[1] ? 4'b0011 : 4'b1111);
            check("room", (nbuf + (fetch_pc[1] ? 32'd1 : 32'd2)) <= 32'(DEPTH), 1'b1);
        end

        i_wb_ack = 1'b0;
        i_wb_err = 1'b0;
        if (!o_wb_cyc) begin
            req_active = 1'b0;
        end else begin
            if (!req_active) begin
                req_active = 1'b1;
                wait_left  = $urandom_range(min_wait, max_wait);
            end
            if (wait_left == 0) begin
                if (err_en && o_wb_addr == err_addr_trig) begin
                    i_wb_err = 1'b1;
                    i_wb_dat = $urandom;
                end else begin
                    i_wb_ack = 1'b1;
                    i_wb_dat = mem[o_wb_addr[9:2]];
                    ack_cnt++;
                end
                req_active = 1'b0;
            end else begin
                wait_left--;
            end
        end
        i_ready    = ($urandom_range(0, 99) < ready_pct);
        i_flush    = flush_req;
        i_flush_pc = flush_pc_v;
        if (armed && i_wb_ack && ev && i_ready) begin
            i_flush    = 1'b1;
            i_flush_pc = arm_pc;
            armed      = 1'b0;
            hit        = 1'b1;
        end

        if (i_flush) begin
            pc_exp   = i_flush_pc & ~32'h1;
            fetch_pc = i_flush_pc & ~32'h1;
            err_exp  = 1'b0;
        end else begin
            if (ev && i_ready) begin
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("sb_instr", o_instruction, e[81:34]);
                    check("sb_pc", o_pc, e[33:2]);
                    check("sb_len", o_len, e[1:0]);
                end
                delivered++;
                pc_exp = pc_exp + {29'd0, el, 1'b0};
            end
            if (i_wb_ack) fetch_pc = {fetch_pc[31:2], 2'b00} + 32'd4;
            if (i_wb_err) begin
                err_exp      = 1'b1;
                err_addr_exp = {fetch_pc[31:2], 2'b00};
            end
        end
    endtask

    task automatic do_flush(input logic [31:0] pc);
        flush_req  = 1'b1;
        flush_pc_v = pc;
        step_cycle();
        flush_req  = 1'b0;
    endtask

    task automatic run_until_empty(input string tag, input int budget);
        for (int n = 0; n < budget && exp_q.size() > 0; n++) step_cycle();
        check(tag, exp_q.size(), 0);
    endtask

    initial begin
        int d0;
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        mem[0]          = 32'h0400_0401;
        mem[1][31:16]   = 16'h1234;
        mem[8'h40][15:0] = 16'h0402;
        mem[8'h41]      = 32'h1111_2222;
        mem[8'h42]      = 32'h0000_5555;

        i_reset = 1'b1; i_wb_dat = 32'h0; i_wb_ack = 1'b0; i_wb_err = 1'b0;
        i_flush = 1'b0; i_flush_pc = 32'h0; i_ready = 1'b0;
        ready_pct = 100; min_wait = 0; max_wait = 0; wait_left = 0;
        ack_cnt = 0; delivered = 0; err_en = 1'b0; flush_req = 1'b0;
        armed = 1'b0; hit = 1'b0; err_addr_trig = 32'h0; flush_pc_v = 32'h0; arm_pc = 32'h0;

        // Reset values.
        repeat (2) @(negedge i_clk);
        check("rst_cyc", o_wb_cyc, 1'b0);
        check("rst_stb", o_wb_stb, 1'b0);
        check("rst_sel", o_wb_sel, 4'b0000);
        check("rst_valid", o_valid, 1'b0);
        check("rst_error", o_error, 1'b0);
        check("rst_err_addr", o_error_addr, 32'h0);
        check("rst_pc", o_pc, RST_PC);
        check("rst_we", o_wb_we, 1'b0);
        check("rst_dat", o_wb_dat, 32'h0);
        model_reset();
        i_reset = 1'b0;

        // 16-bit then 32-bit instruction from reset.
        exp_q.push_back({48'h0400_0000_0000, 32'h0000_0000, 2'd1});
        exp_q.push_back({48'h0401_1234_0000, 32'h0000_0002, 2'd2});
        run_until_empty("t1_done", 60);

        // Redirect to a mid-word address: half-word fetch, then a 48-bit instruction.
        exp_q.push_back({48'h0402_1111_2222, 32'h0000_0102, 2'd3});
        exp_q.push_back({48'h0000_0000_0000, 32'h0000_0108, 2'd1});
        do_flush(32'h0000_0102);
        step_cycle();
        step_cycle();
        check("t2_addr", o_wb_addr, 32'h0000_0100);
        check("t2_sel", o_wb_sel, 4'b0011);
        run_until_empty("t2_done", 60);

        // Stalled consumer: the FIFO fills with four word fetches, then the bus idles.
        ready_pct = 0; max_wait = 2;
        do_flush(32'h0000_0040);
        ack_cnt = 0;
        repeat (40) step_cycle();
        check("t3_fetches", ack_cnt, 4);
        check("t3_idle", o_wb_cyc, 1'b0);
        d0 = delivered;
        ready_pct = 100;
        repeat (40) step_cycle();
        check("t3_resume", delivered > d0, 1'b1);

        // Bus error on the third fetch; buffered 16-bit instructions still drain.
        mem[0] = 32'h1110_2220;
        mem[1] = 32'h3330_4440;
        err_en = 1'b1; err_addr_trig = 32'h0000_0008;
        do_flush(32'h0000_0000);
        d0 = delivered;
        repeat (40) step_cycle();
        check("t4_delivered", delivered - d0, 4);
        check("t4_error", o_error, 1'b1);
        check("t4_err_addr", o_error_addr, 32'h0000_0008);
        check("t4_valid", o_valid, 1'b0);
        check("t4_cyc", o_wb_cyc, 1'b0);
        err_en = 1'b0; max_wait = 0;
        mem[8'hC0] = 32'h0000_0000;
        do_flush(32'h0000_0300);
        step_cycle();
        check("t4_err_clr", o_error, 1'b0);
        check("lat_f1_idle", o_wb_cyc, 1'b0);
        step_cycle();
        check("lat_f2_req", o_wb_cyc, 1'b1);
        step_cycle();
        check("lat_f3_valid", o_valid, 1'b1);

        // Flush in the same cycle as an ack and an accept.
        max_wait = 1;
        repeat (5) step_cycle();
        arm_pc = 32'h0000_0222; armed = 1'b1; hit = 1'b0;
        for (int n = 0; n < 200 && !hit; n++) step_cycle();
        armed = 1'b0;
        check("t5_hit", hit, 1'b1);
        step_cycle();
        check("t5_pc", o_pc, 32'h0000_0222);
        check("t5_valid", o_valid, 1'b0);
        check("t5_cyc", o_wb_cyc, 1'b0);

        // Random traffic with redirects, including across the 2^32 wrap.
        d0 = delivered;
        for (int i = 0; i < 1500; i++) begin
            if (i % 100 == 0) ready_pct = $urandom_range(20, 100);
            max_wait = $urandom_range(0, 3);
            if (i == 700) begin
                flush_req = 1'b1; flush_pc_v = 32'hFFFF_FFFA;
            end else if ($urandom_range(0, 59) == 0) begin
                flush_req = 1'b1; flush_pc_v = $urandom & 32'hFFFF_FFFE;
            end
            step_cycle();
            flush_req = 1'b0;
        end
        check("t6_progress", (delivered - d0) > 100, 1'b1);

        // Asynchronous reset while a bus cycle is outstanding.
        min_wait = 4; max_wait = 4;
        for (int n = 0; n < 40 && !o_wb_cyc; n++) step_cycle();
        check("t7_in_bus", o_wb_cyc, 1'b1);
        #2 i_reset = 1'b1;
        i_wb_ack = 1'b0; i_wb_err = 1'b0;
        #1;
        check("t7_cyc", o_wb_cyc, 1'b0);
        check("t7_stb", o_wb_stb, 1'b0);
        check("t7_sel", o_wb_sel, 4'b0000);
        check("t7_valid", o_valid, 1'b0);
        check("t7_error", o_error, 1'b0);
        check("t7_err_addr", o_error_addr, 32'h0);
        check("t7_pc", o_pc, RST_PC);
        @(negedge i_clk);
        i_reset = 1'b0;
        model_reset();
        min_wait = 0; max_wait = 2; ready_pct = 80;
        d0 = delivered;
        repeat (100) step_cycle();
        check("t7_resume", delivered > d0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
